axi_wr_slave: RTL and testbench

AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

---
 rtl/axi_wr_slave_pkg.sv | 18 +
 rtl/axi_byte_ram.sv | 25 ++
 rtl/axi_wr_slave.sv | 133 +++++++++++++
 tb/tb_axi_wr_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_slave_pkg.sv
// Shared write-channel protocol definitions: FSM encoding, default widths
// and the bit positions of the fields packed into BRESP.
package axi_wr_slave_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 8;
    localparam int ID_W_DEF      = 4;
    localparam int MAX_BEATS_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // BRESP = {BID, ERR}
    localparam int BRESP_ERR_BIT = 0;
    localparam int BRESP_ID_LSB  = 1;

endpackage

// File: rtl/axi_byte_ram.sv
// Byte-wide memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately never reset.
module axi_byte_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI-style write slave: accepts one address, a burst of
// byte beats into a local RAM, then returns {ID, ERR} on the B channel.
module axi_wr_slave
    import axi_wr_slave_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   AWVALID,
    input  logic [ADDR_W+ID_W-1:0] AWIN,
    output logic                   AWREADY,
    input  logic                   WVALID,
    input  logic [DATA_W-1:0]      WDATA,
    input  logic                   WLAST,
    output logic                   WREADY,
    output logic                   BVALID,
    output logic [ID_W:0]          BRESP,
    input  logic                   BREADY,
    input  logic [ADDR_W-1:0]      dbg_addr,
    output logic [DATA_W-1:0]      dbg_data
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W:0]     bresp_q, bresp_d;
    logic              mem_we;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AWVALID && awready_q) begin
                    addr_d     = AWIN[ADDR_W+ID_W-1:ID_W];
                    id_d       = AWIN[ID_W-1:0];
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (WVALID && wready_q) begin
                    mem_we     = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    // A later beat landing on address 0 means the burst wrapped.
                    if (beat_cnt_q != '0 && addr_q == '0) begin
                        err_d = 1'b1;
                    end
                    if (WLAST) begin
                        state_d = ST_RESP;
                    end else if (beat_cnt_q == LAST_CNT) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (BREADY && bvalid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered, so derive them from the next state.
        awready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_DATA);
        bvalid_d  = (state_d == ST_RESP);
        bresp_d   = '0;
        bresp_d[BRESP_ERR_BIT]           = err_d;
        bresp_d[BRESP_ID_LSB +: ID_W]    = id_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            id_q       <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

    axi_byte_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (mem_we),
        .waddr(addr_q),
        .wdata(WDATA),
        .raddr(dbg_addr),
        .rdata(dbg_data)
    );

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed plus randomized bench for axi_wr_slave, checked against a
// byte-array model of the memory and the response rules.
module tb_axi_wr_slave;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        AWVALID;
    logic [11:0] AWIN;
    logic        AWREADY;
    logic        WVALID;
    logic [7:0]  WDATA;
    logic        WLAST;
    logic        WREADY;
    logic        BVALID;
    logic [4:0]  BRESP;
    logic        BREADY;
    logic [7:0]  dbg_addr;
    logic [7:0]  dbg_data;

    always #5 clk = ~clk;

    axi_wr_slave #(
        .ADDR_W(8), .DATA_W(8), .ID_W(4), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AWIN(AWIN), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    int         checks = 0;
    int         passed = 0;
    logic [7:0] model_mem [256];
    bit         known [256];
    logic [7:0] beat_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_mem();
        for (int a = 0; a < 256; a++) begin
            if (known[a]) begin
                dbg_addr = a[7:0];
                #1;
                check($sformatf("mem[%02h]", a), {24'h0, dbg_data}, {24'h0, model_mem[a]});
            end
        end
        @(negedge clk);
    endtask

    task automatic do_aw(input logic [7:0] a, input logic [3:0] id);
        int n = 0;
        AWVALID = 1'b1;
        AWIN    = {a, id};
        while (AWREADY !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("aw_accept", AWREADY, 1);
        @(negedge clk);
        AWVALID = 1'b0;
        AWIN    = 12'($urandom);
    endtask

    task automatic w_beat(input logic [7:0] d, input logic last);
        int n = 0;
        WVALID = 1'b1;
        WDATA  = d;
        WLAST  = last;
        while (WREADY !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w_accept", WREADY, 1);
        @(negedge clk);
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic resp(input logic [4:0] exp, input int stall, input bit hold, input logic [11:0] next_awin);
        int n = 0;
        while (BVALID !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b_valid", BVALID, 1);
        check("w_closed", WREADY, 0);
        if (hold) begin
            AWVALID = 1'b1;
            AWIN    = next_awin;
        end
        for (int i = 0; i < stall; i++) begin
            check("b_stall_valid", BVALID, 1);
            check("b_stall_resp", BRESP, exp);
            if (hold) check("aw_blocked", AWREADY, 0);
            @(negedge clk);
        end
        BREADY = 1'b1;
        check("b_resp", BRESP, exp);
        @(negedge clk);
        BREADY = 1'b0;
        check("b_done", BVALID, 0);
        check("aw_ready_after_b", AWREADY, 1);
    endtask

    // Full transaction; the expected outcome comes from the burst rules alone.
    task automatic xact(input logic [7:0] a, input logic [3:0] id, input bit use_last,
                        input bit gapped, input int stall, input bit hold,
                        input logic [11:0] next_awin);
        int         n;
        int         nw;
        bit         err;
        logic [7:0] idx;
        n   = beat_q.size();
        nw  = (!use_last && n > MAXB) ? MAXB : n;
        err = (!use_last && n >= MAXB) || (int'(a) + nw > 256);
        for (int i = 0; i < nw; i++) begin
            idx = a + 8'(i);
            model_mem[idx] = beat_q[i];
            known[idx]     = 1'b1;
        end
        do_aw(a, id);
        for (int i = 0; i < n; i++) begin
            if (i < nw) begin
                w_beat(beat_q[i], use_last && (i == n - 1));
                if (gapped && i != nw - 1) begin
                    WVALID = 1'b0;
                    WDATA  = 8'($urandom);
                    @(negedge clk);
                end
            end else begin
                WVALID = 1'b1;
                WDATA  = beat_q[i];
                WLAST  = 1'b0;
                check("w_ignored", WREADY, 0);
                @(negedge clk);
                WVALID = 1'b0;
            end
        end
        resp({id, err}, stall, hold, next_awin);
        beat_q.delete();
    endtask

    initial begin
        logic [7:0] ra;
        int         rl;
        rst = 1'b1; AWVALID = 1'b0; AWIN = '0; WVALID = 1'b0; WDATA = '0;
        WLAST = 1'b0; BREADY = 1'b0; dbg_addr = '0;
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_bresp", BRESP, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("awready_low_at_release", AWREADY, 0);
        @(negedge clk);
        check("awready_after_release", AWREADY, 1);

        // Preload bytes later used as "unchanged" witnesses.
        for (int i = 0; i < 4; i++) beat_q.push_back(8'($urandom));
        xact(8'h10, 4'h9, 1'b1, 1'b0, 0, 1'b0, 12'h0);
        beat_q.push_back(8'h5A);
        xact(8'h50, 4'h2, 1'b1, 1'b0, 1, 1'b0, 12'h0);

        // Burst of 4 at address 1.
        beat_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        xact(8'h01, 4'h1, 1'b1, 1'b0, 2, 1'b0, 12'h0);
        check_mem();

        // Response backpressure with the next address already waiting.
        for (int i = 0; i < 3; i++) beat_q.push_back(8'($urandom));
        xact(8'h20, 4'h6, 1'b1, 1'b0, 5, 1'b1, {8'hFE, 4'hC});

        // Wrap through 0xFF.
        beat_q = '{8'hAA, 8'hBB, 8'hCC};
        xact(8'hFE, 4'hC, 1'b1, 1'b0, 1, 1'b0, 12'h0);
        check_mem();

        // Overlength: 17 beats, WLAST never asserted.
        for (int i = 0; i < 17; i++) beat_q.push_back(8'($urandom));
        xact(8'h40, 4'h3, 1'b0, 1'b0, 1, 1'b0, 12'h0);
        check_mem();

        // Reset after 2 of 4 beats.
        do_aw(8'h10, 4'h4);
        for (int i = 0; i < 2; i++) begin
            ra = 8'($urandom);
            model_mem[8'h10 + 8'(i)] = ra;
            w_beat(ra, 1'b0);
        end
        WVALID = 1'b1;
        WDATA  = 8'($urandom);
        rst    = 1'b1;
        #1;
        check("midrst_wready", WREADY, 0);
        check("midrst_bvalid", BVALID, 0);
        check("midrst_bresp", BRESP, 0);
        check("midrst_awready", AWREADY, 0);
        @(negedge clk);
        WVALID = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_bvalid", BVALID, 0);
            check("post_rst_awready", AWREADY, 1);
        end
        check_mem();
        beat_q = '{8'h11, 8'h22};
        xact(8'h30, 4'h5, 1'b1, 1'b0, 0, 1'b0, 12'h0);

        // Gapped WVALID.
        for (int i = 0; i < 5; i++) beat_q.push_back(8'($urandom));
        xact(8'h70, 4'hA, 1'b1, 1'b1, 1, 1'b0, 12'h0);
        check_mem();

        // Randomized bursts clear of the wrap boundary.
        for (int t = 0; t < 8; t++) begin
            ra = 8'($urandom_range(96, 224));
            rl = $urandom_range(1, MAXB);
            for (int i = 0; i < rl; i++) beat_q.push_back(8'($urandom));
            xact(ra, 4'($urandom), 1'b1, 1'($urandom), $urandom_range(0, 3), 1'b0, 12'h0);
        end
        check_mem();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
